ex_stage_pipe: RTL and testbench

- Parametrised execute stage for the in-order RV32-style pipeline: operand forwarding from NFWD younger stages, ALU, branch/jump resolution with mispredict redirect, and an iterative multiplier.
- Registered EX/MEM output with valid/stall handshake.
- Sits between the ID/EX register and the memory stage; the redirect drives fetch PC and the flush logic.

---
 rtl/ex_stage_pipe.sv | 237 +++++++++++++++++++++++
 tb/tb_ex_stage_pipe.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage_pipe
// Brief    : RV32-style execute stage with operand forwarding, ALU, branch
//            resolution with redirect, iterative multiplier and EX/MEM register.
//            Define EX_PERF_EN to add retired/mispredict counters.
// Revision : 1.0
// ============================================================================
module ex_stage_pipe #(
  parameter int XLEN   = 32,
  parameter int NFWD   = 2,
  parameter int PC_INC = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           op,
  input  logic                 alu_in2_sel,
  input  logic [XLEN-1:0]      imm,
  input  logic [XLEN-1:0]      pc,
  input  logic [XLEN-1:0]      rv1,
  input  logic [XLEN-1:0]      rv2,
  input  logic [XLEN-1:0]      pred_addr,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  input  logic [4:0]           rd,
  input  logic                 we_rf,
  input  logic [1:0]           rd_sel,
  input  logic [1:0]           pc_sel,
  input  logic [5*NFWD-1:0]    fwd_rd,
  input  logic [XLEN*NFWD-1:0] fwd_data,
  input  logic [NFWD-1:0]      fwd_valid,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4:0]           out_rd,
  output logic                 out_rd_valid,
  output logic [XLEN-1:0]      out_wdata,
  output logic [XLEN-1:0]      out_alu,
  output logic [XLEN-1:0]      out_rv2,
  output logic                 redirect,
  output logic [XLEN-1:0]      redirect_addr
`ifdef EX_PERF_EN
  ,
  output logic [31:0]          perf_retired,
  output logic [31:0]          perf_mispredict
`endif
);

  localparam int c_SHW = $clog2(XLEN);
  localparam int c_CW  = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_CW-1:0]    r_count;
  logic [XLEN-1:0]    r_mcand;
  logic [XLEN-1:0]    r_mplier;
  logic [XLEN-1:0]    r_prod;

  logic [XLEN-1:0]    w_op1;
  logic [XLEN-1:0]    w_op2;
  logic [XLEN-1:0]    w_in2;
  logic [c_SHW-1:0]   w_shamt;
  logic               w_eq;
  logic               w_lt_s;
  logic               w_lt_u;
  logic [XLEN-1:0]    w_alu;
  logic [XLEN-1:0]    w_pc_seq;
  logic [XLEN-1:0]    w_pc_imm;
  logic [XLEN-1:0]    w_target;
  logic [XLEN-1:0]    w_wdata;
  logic               w_mispredict;
  logic               w_mul_start;
  logic               w_xfer;

  // Walk from oldest to youngest so the lowest matching index wins.
  always_comb begin
    w_op1 = rv1;
    w_op2 = rv2;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && (fwd_rd[i*5 +: 5] == rs1) && (rs1 != 5'd0))
        w_op1 = fwd_data[i*XLEN +: XLEN];
      if (fwd_valid[i] && (fwd_rd[i*5 +: 5] == rs2) && (rs2 != 5'd0))
        w_op2 = fwd_data[i*XLEN +: XLEN];
    end
  end

  assign w_in2   = alu_in2_sel ? imm : w_op2;
  assign w_shamt = w_in2[c_SHW-1:0];
  assign w_eq    = (w_op1 == w_in2);
  assign w_lt_s  = ($signed(w_op1) < $signed(w_in2));
  assign w_lt_u  = (w_op1 < w_in2);

  always_comb begin
    w_alu = '0;
    case (op)
      5'd0:  w_alu = w_op1 + w_in2;
      5'd1:  w_alu = w_op1 - w_in2;
      5'd2:  w_alu = w_op1 & w_in2;
      5'd3:  w_alu = w_op1 | w_in2;
      5'd4:  w_alu = w_op1 ^ w_in2;
      5'd5:  w_alu = w_op1 << w_shamt;
      5'd6:  w_alu = w_op1 >> w_shamt;
      5'd7:  w_alu = $signed(w_op1) >>> w_shamt;
      5'd8:  w_alu = {{(XLEN-1){1'b0}}, w_lt_s};
      5'd9:  w_alu = {{(XLEN-1){1'b0}}, w_lt_u};
      5'd10: w_alu = {{(XLEN-1){1'b0}}, w_eq};
      5'd11: w_alu = {{(XLEN-1){1'b0}}, ~w_eq};
      5'd12: w_alu = {{(XLEN-1){1'b0}}, w_lt_s};
      5'd13: w_alu = {{(XLEN-1){1'b0}}, ~w_lt_s};
      5'd14: w_alu = {{(XLEN-1){1'b0}}, w_lt_u};
      5'd15: w_alu = {{(XLEN-1){1'b0}}, ~w_lt_u};
      5'd16: w_alu = r_prod;
      default: w_alu = '0;
    endcase
  end

  assign w_pc_seq = pc + XLEN'(PC_INC);
  assign w_pc_imm = pc + imm;

  always_comb begin
    w_target = w_pc_seq;
    case (pc_sel)
      2'd0: w_target = w_pc_seq;
      2'd1: w_target = w_pc_imm;
      2'd2: w_target = {w_alu[XLEN-1:1], 1'b0};
      2'd3: w_target = w_alu[0] ? w_pc_imm : w_pc_seq;
      default: w_target = w_pc_seq;
    endcase
  end

  always_comb begin
    w_wdata = '0;
    if (we_rf) begin
      case (rd_sel)
        2'd0: w_wdata = w_alu;
        2'd2: w_wdata = w_pc_seq;
        2'd3: w_wdata = w_pc_imm;
        default: w_wdata = '0;
      endcase
    end
  end

  assign w_mispredict = (pc_sel != 2'd0) && (w_target != pred_addr);

  // A MUL seen in IDLE is captured into the multiplier, not accepted yet.
  assign w_mul_start = (r_state == S_IDLE) && in_valid && (op == 5'd16);
  assign in_ready    = (~out_valid | out_ready)
                     & ((r_state == S_IDLE) | (r_state == S_DONE))
                     & ~w_mul_start;
  assign w_xfer      = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mul_start) begin
            r_mcand  <= w_op1;
            r_mplier <= w_in2;
            r_prod   <= '0;
            r_count  <= c_CW'(XLEN);
            r_state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_mplier[0])
            r_prod <= r_prod + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count - c_CW'(1);
          if (r_count == c_CW'(1))
            r_state <= S_DONE;
        end
        S_DONE: begin
          if (w_xfer)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_rd        <= '0;
      out_rd_valid  <= 1'b0;
      out_wdata     <= '0;
      out_alu       <= '0;
      out_rv2       <= '0;
      redirect      <= 1'b0;
      redirect_addr <= '0;
    end else begin
      redirect <= 1'b0;
      if (w_xfer) begin
        out_valid     <= 1'b1;
        out_rd        <= rd;
        out_rd_valid  <= we_rf;
        out_wdata     <= w_wdata;
        out_alu       <= w_alu;
        out_rv2       <= w_op2;
        redirect      <= w_mispredict;
        redirect_addr <= w_target;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef EX_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_retired    <= '0;
      perf_mispredict <= '0;
    end else begin
      if (w_xfer)
        perf_retired <= perf_retired + 32'd1;
      if (w_xfer && w_mispredict)
        perf_mispredict <= perf_mispredict + 32'd1;
    end
  end
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_ex_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_stage_pipe
// Brief    : Scoreboard bench for ex_stage_pipe (XLEN=32, NFWD=2).
// Revision : 1.0
// ============================================================================
module tb_ex_stage_pipe;

  localparam int XLEN = 32;
  localparam int NFWD = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        op;
  logic              alu_in2_sel;
  logic [31:0]       imm, pc, rv1, rv2, pred_addr;
  logic [4:0]        rs1, rs2, rd;
  logic              we_rf;
  logic [1:0]        rd_sel, pc_sel;
  logic [9:0]        fwd_rd;
  logic [63:0]       fwd_data;
  logic [1:0]        fwd_valid;
  logic              out_valid;
  logic              out_ready;
  logic [4:0]        out_rd;
  logic              out_rd_valid;
  logic [31:0]       out_wdata, out_alu, out_rv2;
  logic              redirect;
  logic [31:0]       redirect_addr;
`ifdef EX_PERF_EN
  logic [31:0]       perf_retired, perf_mispredict;
`endif

  always #5 clk = ~clk;

  ex_stage_pipe #(.XLEN(XLEN), .NFWD(NFWD), .PC_INC(4)) dut (
    .clk(clk),
`ifdef EX_PERF_EN
    .perf_retired(perf_retired),
    .perf_mispredict(perf_mispredict),
`endif
    .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .alu_in2_sel(alu_in2_sel), .imm(imm), .pc(pc), .rv1(rv1), .rv2(rv2),
    .pred_addr(pred_addr), .rs1(rs1), .rs2(rs2), .rd(rd), .we_rf(we_rf),
    .rd_sel(rd_sel), .pc_sel(pc_sel), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .fwd_valid(fwd_valid), .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_rd_valid(out_rd_valid), .out_wdata(out_wdata),
    .out_alu(out_alu), .out_rv2(out_rv2), .redirect(redirect),
    .redirect_addr(redirect_addr)
  );

  typedef struct {
    logic [4:0] op; logic sel2;
    logic [31:0] imm, pc, rv1, rv2, pred;
    logic [4:0] rs1, rs2, rd;
    logic we; logic [1:0] rd_sel, pc_sel;
  } ins_t;

  typedef struct {
    logic [4:0] rd; logic rdv;
    logic [31:0] wdata, alu, rv2;
    logic redir; logic [31:0] raddr;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic ins_t mk_ins(input logic [4:0] o, input logic s2, input logic [31:0] im,
                                  input logic [31:0] p, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] pr, input logic [4:0] r1, input logic [4:0] r2,
                                  input logic [4:0] d, input logic w, input logic [1:0] rs,
                                  input logic [1:0] ps);
    ins_t s;
    s.op = o; s.sel2 = s2; s.imm = im; s.pc = p; s.rv1 = a; s.rv2 = b; s.pred = pr;
    s.rs1 = r1; s.rs2 = r2; s.rd = d; s.we = w; s.rd_sel = rs; s.pc_sel = ps;
    return s;
  endfunction

  function automatic exp_t mk_exp(input logic [4:0] d, input logic v, input logic [31:0] wd,
                                  input logic [31:0] al, input logic [31:0] b, input logic rr,
                                  input logic [31:0] ra);
    exp_t e;
    e.rd = d; e.rdv = v; e.wdata = wd; e.alu = al; e.rv2 = b; e.redir = rr; e.raddr = ra;
    return e;
  endfunction

  task automatic apply(input ins_t s);
    op = s.op; alu_in2_sel = s.sel2; imm = s.imm; pc = s.pc; rv1 = s.rv1; rv2 = s.rv2;
    pred_addr = s.pred; rs1 = s.rs1; rs2 = s.rs2; rd = s.rd; we_rf = s.we;
    rd_sel = s.rd_sel; pc_sel = s.pc_sel;
  endtask

  task automatic clear_fwd();
    fwd_rd = '0; fwd_data = '0; fwd_valid = '0;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input ins_t s, input exp_t e, input string name);
    int n;
    apply(s);
    in_valid = 1'b1;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL %s accept: in_ready stayed 0, required 1 within 100 cycles", name);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back(e);
      #1 in_valid = 1'b0;
    end
  endtask

  // Pops the oldest expectation when the EX/MEM register shows valid.
  task automatic expect_out(input string name);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!out_valid || exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s out_valid: got %0b (queue %0d), required 1", name, out_valid, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      checks++; if (out_alu !== e.alu) begin errors++; $display("FAIL %s out_alu: got %h, required %h", name, out_alu, e.alu); end
      checks++; if (out_wdata !== e.wdata) begin errors++; $display("FAIL %s out_wdata: got %h, required %h", name, out_wdata, e.wdata); end
      checks++; if (out_rd !== e.rd || out_rd_valid !== e.rdv) begin errors++; $display("FAIL %s out_rd: got %0d/%0b, required %0d/%0b", name, out_rd, out_rd_valid, e.rd, e.rdv); end
      checks++; if (out_rv2 !== e.rv2) begin errors++; $display("FAIL %s out_rv2: got %h, required %h", name, out_rv2, e.rv2); end
      checks++; if (redirect !== e.redir) begin errors++; $display("FAIL %s redirect: got %0b, required %0b", name, redirect, e.redir); end
      if (e.redir) begin
        checks++; if (redirect_addr !== e.raddr) begin errors++; $display("FAIL %s redirect_addr: got %h, required %h", name, redirect_addr, e.raddr); end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_rd_valid !== 1'b0 || redirect !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got v=%0b rdv=%0b redir=%0b, required 0/0/0", out_valid, out_rd_valid, redirect);
    end
    checks++;
    if (out_alu !== 32'd0 || out_wdata !== 32'd0 || out_rv2 !== 32'd0 || out_rd !== 5'd0 || redirect_addr !== 32'd0) begin
      errors++; $display("FAIL reset_data: got alu=%h wd=%h rv2=%h rd=%0d ra=%h, required all 0", out_alu, out_wdata, out_rv2, out_rd, redirect_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got in_ready=%0b out_valid=%0b, required 1/0", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_forward();
    fwd_rd = {5'd0, 5'd1}; fwd_data = {32'd0, 32'd100}; fwd_valid = 2'b01;
    send(mk_ins(5'd0, 1'b0, 0, 0, 32'd5, 32'd7, 0, 5'd1, 5'd2, 5'd5, 1'b1, 2'd0, 2'd0),
         mk_exp(5'd5, 1'b1, 32'd107, 32'd107, 32'd7, 1'b0, 0), "fwd_rs1");
    expect_out("fwd_rs1");
    fwd_rd = {5'd2, 5'd0}; fwd_data = {32'd40, 32'd55}; fwd_valid = 2'b11;
    send(mk_ins(5'd0, 1'b0, 0, 0, 32'd3, 32'd7, 0, 5'd0, 5'd2, 5'd6, 1'b1, 2'd0, 2'd0),
         mk_exp(5'd6, 1'b1, 32'd43, 32'd43, 32'd40, 1'b0, 0), "fwd_x0");
    expect_out("fwd_x0");
    clear_fwd();
  endtask

  task automatic test_priority();
    fwd_rd = {5'd3, 5'd3}; fwd_data = {32'd22, 32'd11}; fwd_valid = 2'b11;
    send(mk_ins(5'd1, 1'b0, 0, 0, 32'd0, 32'd1, 0, 5'd3, 5'd4, 5'd8, 1'b1, 2'd0, 2'd0),
         mk_exp(5'd8, 1'b1, 32'd10, 32'd10, 32'd1, 1'b0, 0), "fwd_priority");
    expect_out("fwd_priority");
    clear_fwd();
  endtask

  task automatic test_alu_ops();
    logic [4:0]  ops [17] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
                              5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd20};
    logic [31:0] res [17] = '{32'hF000_0014, 32'hF000_000C, 32'h0, 32'hF000_0014,
                              32'hF000_0014, 32'h0000_0100, 32'h0F00_0001, 32'hFF00_0001,
                              32'h1, 32'h0, 32'h0, 32'h1, 32'h1, 32'h0, 32'h0, 32'h1, 32'h0};
    for (int i = 0; i < 17; i++) begin
      send(mk_ins(ops[i], 1'b0, 0, 0, 32'hF000_0010, 32'd4, 0, 5'd9, 5'd10, 5'd7, 1'b0, 2'd0, 2'd0),
           mk_exp(5'd7, 1'b0, 32'd0, res[i], 32'd4, 1'b0, 0), $sformatf("alu_op%0d", ops[i]));
      expect_out($sformatf("alu_op%0d", ops[i]));
    end
    send(mk_ins(5'd5, 1'b0, 0, 0, 32'hF000_0010, 32'h24, 0, 5'd9, 5'd10, 5'd7, 1'b0, 2'd0, 2'd0),
         mk_exp(5'd7, 1'b0, 32'd0, 32'h0000_0100, 32'h24, 1'b0, 0), "sll_mask");
    expect_out("sll_mask");
    send(mk_ins(5'd7, 1'b0, 0, 0, 32'hF000_0010, 32'h3F, 0, 5'd9, 5'd10, 5'd7, 1'b0, 2'd0, 2'd0),
         mk_exp(5'd7, 1'b0, 32'd0, 32'hFFFF_FFFF, 32'h3F, 1'b0, 0), "sra_31");
    expect_out("sra_31");
  endtask

  task automatic test_mul();
    int low = 0;
    apply(mk_ins(5'd16, 1'b1, 32'd7, 0, 32'd6, 32'd0, 0, 5'd11, 5'd0, 5'd4, 1'b1, 2'd0, 2'd0));
    in_valid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (in_ready) break;
      low++;
    end
    checks++;
    if (low != 33) begin
      errors++; $display("FAIL mul_latency: in_ready low %0d cycles, required 33", low);
    end
    @(posedge clk);
    exp_q.push_back(mk_exp(5'd4, 1'b1, 32'd42, 32'd42, 32'd0, 1'b0, 0));
    #1 in_valid = 1'b0;
    expect_out("mul_6x7");
    send(mk_ins(5'd16, 1'b0, 0, 0, 32'hFFFF_FFFF, 32'd2, 0, 5'd12, 5'd13, 5'd4, 1'b1, 2'd0, 2'd0),
         mk_exp(5'd4, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd2, 1'b0, 0), "mul_wrap");
    expect_out("mul_wrap");
  endtask

  task automatic test_branch();
    send(mk_ins(5'd10, 1'b0, 32'h20, 32'h100, 32'h55, 32'h55, 32'h104, 5'd6, 5'd7, 5'd0, 1'b0, 2'd0, 2'd3),
         mk_exp(5'd0, 1'b0, 32'd0, 32'd1, 32'h55, 1'b1, 32'h120), "beq_mispredict");
    expect_out("beq_mispredict");
    @(negedge clk);
    checks++;
    if (redirect !== 1'b0) begin
      errors++; $display("FAIL redirect_pulse: got %0b one cycle later, required 0", redirect);
    end
    @(posedge clk);
    #1;
    send(mk_ins(5'd10, 1'b0, 32'h20, 32'h100, 32'h55, 32'h55, 32'h120, 5'd6, 5'd7, 5'd0, 1'b0, 2'd0, 2'd3),
         mk_exp(5'd0, 1'b0, 32'd0, 32'd1, 32'h55, 1'b0, 0), "beq_predicted");
    expect_out("beq_predicted");
    send(mk_ins(5'd11, 1'b0, 32'h20, 32'h100, 32'h55, 32'h55, 32'h104, 5'd6, 5'd7, 5'd0, 1'b0, 2'd0, 2'd3),
         mk_exp(5'd0, 1'b0, 32'd0, 32'd0, 32'h55, 1'b0, 0), "bne_not_taken");
    expect_out("bne_not_taken");
    send(mk_ins(5'd10, 1'b0, 32'h20, 32'h100, 32'h55, 32'h56, 32'h120, 5'd6, 5'd7, 5'd0, 1'b0, 2'd0, 2'd3),
         mk_exp(5'd0, 1'b0, 32'd0, 32'd0, 32'h56, 1'b1, 32'h104), "beq_fallthrough");
    expect_out("beq_fallthrough");
  endtask

  task automatic test_jump();
    send(mk_ins(5'd0, 1'b1, 32'd0, 32'h40, 32'h203, 32'd0, 32'h44, 5'd8, 5'd0, 5'd1, 1'b1, 2'd2, 2'd2),
         mk_exp(5'd1, 1'b1, 32'h44, 32'h203, 32'd0, 1'b1, 32'h202), "jalr");
    expect_out("jalr");
    send(mk_ins(5'd0, 1'b1, 32'h10, 32'h40, 32'd0, 32'd0, 32'h50, 5'd0, 5'd0, 5'd2, 1'b1, 2'd3, 2'd1),
         mk_exp(5'd2, 1'b1, 32'h50, 32'h10, 32'd0, 1'b0, 0), "jal_pc_imm");
    expect_out("jal_pc_imm");
    send(mk_ins(5'd0, 1'b0, 0, 0, 32'd1, 32'd2, 0, 5'd14, 5'd15, 5'd3, 1'b1, 2'd1, 2'd0),
         mk_exp(5'd3, 1'b1, 32'd0, 32'd3, 32'd2, 1'b0, 0), "rd_sel1");
    expect_out("rd_sel1");
    send(mk_ins(5'd0, 1'b0, 0, 32'hFFFF_FFFC, 32'd1, 32'd1, 32'd0, 5'd14, 5'd15, 5'd3, 1'b1, 2'd2, 2'd0),
         mk_exp(5'd3, 1'b1, 32'd0, 32'd2, 32'd1, 1'b0, 0), "pc_wrap");
    expect_out("pc_wrap");
  endtask

  task automatic test_back_to_back();
    int got = 0;
    int cyc = 0;
    exp_t e;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(mk_ins(5'd0, 1'b0, 0, 0, 32'(100*i + 1), 32'(i + 7), 0, 5'd12, 5'd13, 5'(i + 1), 1'b1, 2'd0, 2'd0),
               mk_exp(5'(i + 1), 1'b1, 32'(101*i + 8), 32'(101*i + 8), 32'(i + 7), 1'b0, 0), "b2b");
      end
      begin
        while (got < 6 && cyc < 40) begin
          @(negedge clk);
          cyc++;
          if (out_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (out_alu !== e.alu || out_wdata !== e.wdata || out_rd !== e.rd) begin
              errors++; $display("FAIL b2b_%0d: got alu=%h wd=%h rd=%0d, required %h/%h/%0d", got, out_alu, out_wdata, out_rd, e.alu, e.wdata, e.rd);
            end
            got++;
          end
        end
      end
    join
    checks++;
    if (got != 6 || cyc != 7) begin
      errors++; $display("FAIL b2b_count: got %0d outputs in %0d cycles, required 6 in 7", got, cyc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_hold();
    exp_t e;
    out_ready = 1'b0;
    send(mk_ins(5'd0, 1'b0, 0, 0, 32'd10, 32'd20, 0, 5'd12, 5'd13, 5'd9, 1'b1, 2'd0, 2'd0),
         mk_exp(5'd9, 1'b1, 32'd30, 32'd30, 32'd20, 1'b0, 0), "hold_a");
    apply(mk_ins(5'd0, 1'b0, 0, 0, 32'd1, 32'd1, 0, 5'd12, 5'd13, 5'd10, 1'b1, 2'd0, 2'd0));
    in_valid = 1'b1;
    e = exp_q.pop_front();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_alu !== e.alu || out_wdata !== e.wdata || out_rd !== e.rd || in_ready !== 1'b0) begin
        errors++; $display("FAIL hold_%0d: got v=%0b alu=%h wd=%h rd=%0d rdy=%0b, required 1/%h/%h/%0d/0", k, out_valid, out_alu, out_wdata, out_rd, in_ready, e.alu, e.wdata, e.rd);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    exp_q.push_back(mk_exp(5'd10, 1'b1, 32'd2, 32'd2, 32'd1, 1'b0, 0));
    #1 in_valid = 1'b0;
    expect_out("hold_b");
  endtask

  task automatic test_reset_mid_mul();
    apply(mk_ins(5'd16, 1'b0, 0, 0, 32'd9, 32'd9, 0, 5'd1, 5'd2, 5'd3, 1'b1, 2'd0, 2'd0));
    in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_rd_valid !== 1'b0 || redirect !== 1'b0 || out_rd !== 5'd0) begin
      errors++; $display("FAIL midmul_flags: got v=%0b rdv=%0b redir=%0b rd=%0d, required 0", out_valid, out_rd_valid, redirect, out_rd);
    end
    checks++;
    if (out_alu !== 32'd0 || out_wdata !== 32'd0 || out_rv2 !== 32'd0 || redirect_addr !== 32'd0) begin
      errors++; $display("FAIL midmul_data: got alu=%h wd=%h rv2=%h ra=%h, required 0", out_alu, out_wdata, out_rv2, redirect_addr);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL midmul_idle: in_ready got %0b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
    send(mk_ins(5'd0, 1'b0, 0, 0, 32'd2, 32'd3, 0, 5'd1, 5'd2, 5'd3, 1'b1, 2'd0, 2'd0),
         mk_exp(5'd3, 1'b1, 32'd5, 32'd5, 32'd3, 1'b0, 0), "after_reset");
    expect_out("after_reset");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    apply(mk_ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    clear_fwd();
    repeat (3) @(posedge clk);
    test_reset();
    test_forward();
    test_priority();
    test_alu_ops();
    test_mul();
    test_branch();
    test_jump();
    test_back_to_back();
    test_hold();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
